// File: rtl/if_fetch_pkg.sv
// Shared widths, reset PC, NOP encoding and fetch FSM states for the
// instruction-fetch stage.
package if_fetch_pkg;

  localparam int INST_BUS = 32;
  localparam int ADDR_BUS = 64;
  localparam int DATA_BUS = 64;

  localparam logic [ADDR_BUS-1:0] RESET_PC = 64'h8000_0000;
  localparam logic [INST_BUS-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_ST_REQ  = 2'd0,
    IF_ST_WAIT = 2'd1,
    IF_ST_HOLD = 2'd2
  } if_state_e;

  // Bus reads are always 64-bit aligned; the low PC bits only pick the half.
  function automatic logic [ADDR_BUS-1:0] line_addr(input logic [ADDR_BUS-1:0] pc);
    return {pc[ADDR_BUS-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/if_inst_sel.sv
// Combinational 64->32 half-select of a fetched bus word, chosen by pc[2].
module if_inst_sel
  import if_fetch_pkg::*;
(
  input  logic [DATA_BUS-1:0] data,
  input  logic                hi_sel,
  output logic [INST_BUS-1:0] inst
);

  assign inst = hi_sel ? data[DATA_BUS-1:INST_BUS] : data[INST_BUS-1:0];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, single outstanding bus read, stale-response
// discard on redirect. Optional misaligned-fetch fault under IF_MISALIGN_TRAP_EN.
module if_fetch
  import if_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  output logic                ifetch_req_valid,
  input  logic                ifetch_req_ready,
  output logic [ADDR_BUS-1:0] ifetch_addr,
  input  logic                ifetch_resp_valid,
  input  logic [DATA_BUS-1:0] ifetch_resp_data,
  input  logic                redirect_valid,
  input  logic [ADDR_BUS-1:0] redirect_pc,
  output logic [INST_BUS-1:0] inst,
  output logic                inst_valid,
  output logic [ADDR_BUS-1:0] inst_pc,
`ifdef IF_MISALIGN_TRAP_EN
  output logic                if_fault,
`endif
  input  logic                id_ready
);

  if_state_e           state, state_n;
  logic [ADDR_BUS-1:0] pc, pc_n;
  logic [ADDR_BUS-1:0] addr_q, addr_n;
  logic                discard, discard_n;
  logic                load_inst, load_fault;
  logic                misalign;
  logic [INST_BUS-1:0] sel_inst;

  // A stale request already on the bus must still complete, so the fault
  // path is only taken once no discard is pending.
`ifdef IF_MISALIGN_TRAP_EN
  assign misalign = (pc[1:0] != 2'b00) && !discard;
`else
  assign misalign = 1'b0;
`endif

  assign ifetch_req_valid = (state == IF_ST_REQ) && !misalign;
  assign ifetch_addr      = addr_q;

  if_inst_sel u_inst_sel (
    .data   (ifetch_resp_data),
    .hi_sel (pc[2]),
    .inst   (sel_inst)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    discard_n  = discard;
    load_inst  = 1'b0;
    load_fault = 1'b0;
    case (state)
      IF_ST_REQ: begin
        if (redirect_valid) begin
          pc_n = redirect_pc;
          if (!misalign) begin
            discard_n = 1'b1;
            if (ifetch_req_ready) state_n = IF_ST_WAIT;
          end
        end else if (misalign) begin
          load_fault = 1'b1;
          state_n    = IF_ST_HOLD;
        end else if (ifetch_req_ready) begin
          state_n = IF_ST_WAIT;
        end
      end
      IF_ST_WAIT: begin
        if (redirect_valid) begin
          pc_n = redirect_pc;
          if (ifetch_resp_valid) begin
            discard_n = 1'b0;
            state_n   = IF_ST_REQ;
          end else begin
            discard_n = 1'b1;
          end
        end else if (ifetch_resp_valid) begin
          if (discard) begin
            discard_n = 1'b0;
            state_n   = IF_ST_REQ;
          end else begin
            load_inst = 1'b1;
            state_n   = IF_ST_HOLD;
          end
        end
      end
      IF_ST_HOLD: begin
        if (redirect_valid) begin
          pc_n    = redirect_pc;
          state_n = IF_ST_REQ;
        end else if (id_ready) begin
          pc_n    = pc + 64'd4;
          state_n = IF_ST_REQ;
        end
      end
      default: state_n = IF_ST_REQ;
    endcase
  end

  // The address of an offered-but-unaccepted request is frozen; otherwise it
  // follows the PC so the next REQ presents the right line.
  assign addr_n = (ifetch_req_valid && !ifetch_req_ready) ? addr_q : line_addr(pc_n);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IF_ST_REQ;
      pc         <= RESET_PC;
      addr_q     <= line_addr(RESET_PC);
      discard    <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      addr_q     <= addr_n;
      discard    <= discard_n;
      inst_valid <= (state_n == IF_ST_HOLD);
      if (load_inst) begin
        inst    <= sel_inst;
        inst_pc <= pc;
      end else if (load_fault) begin
        inst    <= NOP_INST;
        inst_pc <= pc;
      end
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_fault <= 1'b0;
    end else if (load_fault) begin
      if_fault <= 1'b1;
    end else if (state_n != IF_ST_HOLD) begin
      if_fault <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios, then randomized bus,
// decode and redirect traffic against an instruction-stream reference model.
module tb_if_fetch;

  localparam logic [63:0] BOOT_PC = 64'h8000_0000;
  localparam logic [63:0] D0      = 64'h00500093_00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifetch_req_valid;
  logic        ifetch_req_ready;
  logic [63:0] ifetch_addr;
  logic        ifetch_resp_valid;
  logic [63:0] ifetch_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic [63:0] inst_pc;
  logic        id_ready;
`ifdef IF_MISALIGN_TRAP_EN
  logic        if_fault;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk               (clk),
    .rst               (rst),
    .ifetch_req_valid  (ifetch_req_valid),
    .ifetch_req_ready  (ifetch_req_ready),
    .ifetch_addr       (ifetch_addr),
    .ifetch_resp_valid (ifetch_resp_valid),
    .ifetch_resp_data  (ifetch_resp_data),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .inst              (inst),
    .inst_valid        (inst_valid),
    .inst_pc           (inst_pc),
`ifdef IF_MISALIGN_TRAP_EN
    .if_fault          (if_fault),
`endif
    .id_ready          (id_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Memory image: each 4-byte word holds a value unique to its address.
  function automatic logic [31:0] word_at(input logic [63:0] p);
    logic [63:0] a;
    a = {p[63:2], 2'b00};
    return a[31:0] ^ a[63:32] ^ 32'h1357_9bdf;
  endfunction

  function automatic logic [63:0] mem_line(input logic [63:0] addr);
    logic [63:0] a;
    a = {addr[63:3], 3'b000};
    return {word_at(a + 64'd4), word_at(a)};
  endfunction

  function automatic logic [31:0] exp_inst(input logic [63:0] p);
`ifdef IF_MISALIGN_TRAP_EN
    if (p[1:0] != 2'b00) return 32'h0000_0013;
`endif
    return word_at(p);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // From REQ: handshake, then a response one cycle later; ends in HOLD.
  task automatic fetch_one(input logic [63:0] data);
    ifetch_req_ready = 1'b1;
    tick();
    ifetch_req_ready  = 1'b0;
    ifetch_resp_valid = 1'b1;
    ifetch_resp_data  = data;
    tick();
    ifetch_resp_valid = 1'b0;
  endtask

  task automatic consume();
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
  endtask

  task automatic redirect(input logic [63:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_pc, out_addr, prev_addr;
    logic        outstanding, prev_stall;
    int          delay, idle, max_idle, delivered;

    rst = 1'b1;
    ifetch_req_ready  = 1'b0;
    ifetch_resp_valid = 1'b0;
    ifetch_resp_data  = '0;
    redirect_valid    = 1'b0;
    redirect_pc       = '0;
    id_ready          = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_req_valid", ifetch_req_valid, 1);
    check("rst_addr", ifetch_addr, BOOT_PC);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);

    // First fetch: inst_valid two cycles after the handshake.
    ifetch_req_ready = 1'b1;
    tick();
    ifetch_req_ready = 1'b0;
    check("wait_no_req", ifetch_req_valid, 0);
    check("wait_no_inst", inst_valid, 0);
    ifetch_resp_valid = 1'b1;
    ifetch_resp_data  = D0;
    tick();
    ifetch_resp_valid = 1'b0;
    check("first_valid", inst_valid, 1);
    check("first_inst", inst, 32'h0000_0013);
    check("first_pc", inst_pc, BOOT_PC);

    repeat (5) begin
      tick();
      check("hold_valid", inst_valid, 1);
      check("hold_inst", inst, 32'h0000_0013);
      check("hold_pc", inst_pc, BOOT_PC);
    end
    consume();
    check("next_addr", ifetch_addr, 64'h8000_0000);
    check("next_req", ifetch_req_valid, 1);
    check("consumed_valid", inst_valid, 0);
    fetch_one(D0);
    check("upper_inst", inst, 32'h0050_0093);
    check("upper_pc", inst_pc, 64'h8000_0004);

    // Redirect while waiting for a response.
    consume();
    check("seq_addr", ifetch_addr, 64'h8000_0008);
    ifetch_req_ready = 1'b1;
    tick();
    ifetch_req_ready = 1'b0;
    redirect(64'h8000_0100);
    ifetch_resp_valid = 1'b1;
    ifetch_resp_data  = 64'hDEAD;
    tick();
    ifetch_resp_valid = 1'b0;
    check("wait_redir_valid", inst_valid, 0);
    check("wait_redir_req", ifetch_req_valid, 1);
    check("wait_redir_addr", ifetch_addr, 64'h8000_0100);

    // Redirect while the request is offered but not accepted.
    redirect(64'h8000_0200);
    repeat (2) begin
      check("stall_addr", ifetch_addr, 64'h8000_0100);
      check("stall_req", ifetch_req_valid, 1);
      tick();
    end
    fetch_one(64'hDEAD);
    check("stale_drop_valid", inst_valid, 0);
    check("stale_new_addr", ifetch_addr, 64'h8000_0200);
    fetch_one(D0);
    check("after_stale_pc", inst_pc, 64'h8000_0200);
    check("after_stale_inst", inst, 32'h0000_0013);

    // Redirect coinciding with id_ready: redirect wins.
    id_ready = 1'b1;
    redirect(64'h8000_0300);
    id_ready = 1'b0;
    check("redir_ready_valid", inst_valid, 0);
    check("redir_ready_addr", ifetch_addr, 64'h8000_0300);
    fetch_one(D0);
    check("redir_ready_pc", inst_pc, 64'h8000_0300);

    // Redirect coinciding with the response.
    consume();
    ifetch_req_ready = 1'b1;
    tick();
    ifetch_req_ready  = 1'b0;
    ifetch_resp_valid = 1'b1;
    ifetch_resp_data  = 64'hDEAD;
    redirect(64'h8000_0400);
    ifetch_resp_valid = 1'b0;
    check("redir_resp_valid", inst_valid, 0);
    check("redir_resp_addr", ifetch_addr, 64'h8000_0400);
    fetch_one(D0);
    check("redir_resp_pc", inst_pc, 64'h8000_0400);

    // 64-bit PC wrap.
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_addr", ifetch_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    fetch_one(D0);
    check("wrap_inst", inst, 32'h0050_0093);
    consume();
    check("wrap_next_addr", ifetch_addr, 64'h0);
    fetch_one(D0);
    check("wrap_next_pc", inst_pc, 64'h0);

`ifdef IF_MISALIGN_TRAP_EN
    redirect(64'h8000_0002);
    check("mis_no_req", ifetch_req_valid, 0);
    tick();
    check("mis_fault", if_fault, 1);
    check("mis_valid", inst_valid, 1);
    check("mis_inst", inst, 32'h0000_0013);
    check("mis_pc", inst_pc, 64'h8000_0002);
    redirect(64'h8000_0000);
    check("mis_clear", if_fault, 0);
    fetch_one(D0);
`else
    redirect(64'h8000_0006);
    check("mis_addr", ifetch_addr, 64'h8000_0000);
    fetch_one(D0);
    check("mis_inst", inst, 32'h0050_0093);
    check("mis_pc", inst_pc, 64'h8000_0006);
`endif

    // Reset mid-transaction; the response during reset is ignored.
    consume();
    ifetch_req_ready = 1'b1;
    tick();
    ifetch_req_ready  = 1'b0;
    rst               = 1'b1;
    ifetch_resp_valid = 1'b1;
    ifetch_resp_data  = D0;
    repeat (2) tick();
    ifetch_resp_valid = 1'b0;
    rst               = 1'b0;
    check("mid_rst_valid", inst_valid, 0);
    check("mid_rst_inst", inst, 0);
    check("mid_rst_req", ifetch_req_valid, 1);
    check("mid_rst_addr", ifetch_addr, BOOT_PC);

    // Randomized traffic against the instruction-stream model.
    exp_pc      = BOOT_PC;
    outstanding = 1'b0;
    out_addr    = '0;
    prev_addr   = '0;
    prev_stall  = 1'b0;
    delay       = 0;
    idle        = 0;
    max_idle    = 0;
    delivered   = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (inst_valid) begin
        check("rnd_pc", inst_pc, exp_pc);
        check("rnd_inst", inst, exp_inst(exp_pc));
        idle = 0;
      end else begin
        idle++;
        if (idle > max_idle) max_idle = idle;
      end
`ifdef IF_MISALIGN_TRAP_EN
      check("rnd_fault", if_fault, inst_valid && (exp_pc[1:0] != 2'b00));
`endif
      if (ifetch_req_valid) begin
        check("rnd_one_outstanding", outstanding, 0);
        check("rnd_addr_align", ifetch_addr[2:0], 0);
        if (prev_stall) check("rnd_addr_stable", ifetch_addr, prev_addr);
      end

      ifetch_req_ready = ($urandom_range(0, 2) != 0);
      if (outstanding && delay == 0) begin
        ifetch_resp_valid = 1'b1;
        ifetch_resp_data  = mem_line(out_addr);
      end else begin
        ifetch_resp_valid = 1'b0;
        ifetch_resp_data  = {$urandom, $urandom};
        if (outstanding) delay--;
      end
      id_ready       = $urandom_range(0, 1) == 1;
      redirect_valid = $urandom_range(0, 15) == 0;
      case ($urandom_range(0, 7))
        0:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4);
        1:       redirect_pc = BOOT_PC + 64'($urandom_range(0, 255) * 4 + 2);
        default: redirect_pc = BOOT_PC + 64'($urandom_range(0, 1023) * 4);
      endcase

      prev_stall = ifetch_req_valid && !ifetch_req_ready;
      prev_addr  = ifetch_addr;
      if (ifetch_resp_valid) outstanding = 1'b0;
      if (ifetch_req_valid && ifetch_req_ready) begin
        outstanding = 1'b1;
        out_addr    = ifetch_addr;
        delay       = $urandom_range(0, 2);
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc;
      end else if (inst_valid && id_ready) begin
        exp_pc = exp_pc + 64'd4;
        delivered++;
      end
      tick();
    end
    check("rnd_delivered", delivered > 50, 1);
    check("rnd_liveness", max_idle < 300, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
